// File: rtl/usbpd_rx_sym_decoder.sv
// rtl/usbpd_rx_sym_decoder.sv - USB PD Rx framer: ordered-set hunt, 4b5b decode, EOP detect, CRC32 check.
// Optional USBPD_RX_SOPDBG_EN: also match SOP'_Debug (code 4) and SOP''_Debug (code 5).
module usbpd_rx_sym_decoder #(
   parameter int MAX_BYTE = 34,
   parameter int CNT_W    = 6
) (
   input  logic             clk,
   input  logic             rstz,
   input  logic             bit_vld,
   input  logic             bit_dat,
   input  logic             bmc_idle,
   output logic             rx_sop,
   output logic [2:0]       rx_ordrs,
   output logic             rx_dv,
   output logic [7:0]       rx_dat,
   output logic [CNT_W-1:0] rx_cnt,
   output logic             rx_eop,
   output logic             rx_crc_ok,
   output logic             rx_err
);

   localparam logic [4:0] K_S1  = 5'b11000;
   localparam logic [4:0] K_S2  = 5'b10001;
   localparam logic [4:0] K_S3  = 5'b00110;
   localparam logic [4:0] K_R1  = 5'b00111;
   localparam logic [4:0] K_R2  = 5'b11001;
   localparam logic [4:0] K_EOP = 5'b01101;

   // First-received symbol sits in the low bits, matching the LSB-first shift.
   localparam logic [19:0] OS_SOP   = {K_S2, K_S1, K_S1, K_S1};
   localparam logic [19:0] OS_SOPP  = {K_S3, K_S3, K_S1, K_S1};
   localparam logic [19:0] OS_SOPPP = {K_S3, K_S1, K_S3, K_S1};
   localparam logic [19:0] OS_HR    = {K_R2, K_R1, K_R1, K_R1};
   localparam logic [19:0] OS_CR    = {K_S3, K_R1, K_S1, K_R1};
`ifdef USBPD_RX_SOPDBG_EN
   localparam logic [19:0] OS_DBGP  = {K_S3, K_R2, K_R2, K_S1};
   localparam logic [19:0] OS_DBGPP = {K_S2, K_S3, K_R2, K_S1};
`endif

   // 0xC704DD7B residue expressed in the reflected register's bit order.
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [0:0] {HUNT, DATA} state_t;

   state_t      state_q, state_d;
   logic [19:0] sr_q, sr_d, sr_shift;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic        odd_q, odd_d;
   logic [3:0]  lo_nib_q, lo_nib_d;
   logic [31:0] crc_q, crc_d;
   logic        sop_d, dv_d, eop_d, ok_d, err_d;
   logic [2:0]  ordrs_d, ord_code;
   logic [7:0]  dat_d;
   logic [CNT_W-1:0] cnt_d;
   logic [4:0]  sym, sym_dec;
   logic        sym_done, eop_now;

   function automatic logic os_hit(input logic [19:0] w, input logic [19:0] os);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++)
         if (w[i*5 +: 5] == os[i*5 +: 5]) n = n + 3'd1;
      return (n >= 3'd3);
   endfunction

   // Returns {valid, nibble}; K codes and unused codes decode as invalid.
   function automatic logic [4:0] dec_sym(input logic [4:0] s);
      case (s)
         5'b11110: return {1'b1, 4'h0};
         5'b01001: return {1'b1, 4'h1};
         5'b10100: return {1'b1, 4'h2};
         5'b10101: return {1'b1, 4'h3};
         5'b01010: return {1'b1, 4'h4};
         5'b01011: return {1'b1, 4'h5};
         5'b01110: return {1'b1, 4'h6};
         5'b01111: return {1'b1, 4'h7};
         5'b10010: return {1'b1, 4'h8};
         5'b10011: return {1'b1, 4'h9};
         5'b10110: return {1'b1, 4'hA};
         5'b10111: return {1'b1, 4'hB};
         5'b11010: return {1'b1, 4'hC};
         5'b11011: return {1'b1, 4'hD};
         5'b11100: return {1'b1, 4'hE};
         5'b11101: return {1'b1, 4'hF};
         default:  return 5'b0_0000;
      endcase
   endfunction

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   assign sr_shift = {bit_dat, sr_q[19:1]};
   assign sym      = sr_shift[19:15];
   assign sym_dec  = dec_sym(sym);
   assign sym_done = bit_vld && (bit_cnt_q == 3'd4);
   assign eop_now  = sym_done && (sym == K_EOP) && !odd_q;

   always_comb begin
      ord_code = 3'd0;
      if (os_hit(sr_shift, OS_SOP))        ord_code = 3'd1;
      else if (os_hit(sr_shift, OS_SOPP))  ord_code = 3'd2;
      else if (os_hit(sr_shift, OS_SOPPP)) ord_code = 3'd3;
      else if (os_hit(sr_shift, OS_HR))    ord_code = 3'd6;
      else if (os_hit(sr_shift, OS_CR))    ord_code = 3'd7;
`ifdef USBPD_RX_SOPDBG_EN
      else if (os_hit(sr_shift, OS_DBGP))  ord_code = 3'd4;
      else if (os_hit(sr_shift, OS_DBGPP)) ord_code = 3'd5;
`endif
   end

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      odd_d     = odd_q;
      lo_nib_d  = lo_nib_q;
      crc_d     = crc_q;
      sop_d     = 1'b0;
      ordrs_d   = rx_ordrs;
      dv_d      = 1'b0;
      dat_d     = rx_dat;
      cnt_d     = rx_cnt;
      eop_d     = 1'b0;
      ok_d      = rx_crc_ok;
      err_d     = 1'b0;
      case (state_q)
         HUNT: begin
            if (bit_vld) begin
               sr_d = sr_shift;
               if (ord_code != 3'd0) begin
                  sop_d     = 1'b1;
                  ordrs_d   = ord_code;
                  cnt_d     = '0;
                  sr_d      = '0;
                  bit_cnt_d = 3'd0;
                  odd_d     = 1'b0;
                  crc_d     = 32'hFFFFFFFF;
                  if (ord_code <= 3'd5) state_d = DATA;
               end
            end
         end
         DATA: begin
            if (bit_vld) begin
               sr_d      = sr_shift;
               bit_cnt_d = sym_done ? 3'd0 : bit_cnt_q + 3'd1;
            end
            // EOP completing in the same cycle as squelch takes priority.
            if (bmc_idle && !eop_now) begin
               err_d   = 1'b1;
               state_d = HUNT;
               sr_d    = '0;
            end else if (sym_done) begin
               if (sym_dec[4]) begin
                  if (!odd_q) begin
                     lo_nib_d = sym_dec[3:0];
                     odd_d    = 1'b1;
                  end else if (rx_cnt == CNT_W'(MAX_BYTE)) begin
                     err_d   = 1'b1;
                     state_d = HUNT;
                     sr_d    = '0;
                  end else begin
                     dv_d  = 1'b1;
                     dat_d = {sym_dec[3:0], lo_nib_q};
                     cnt_d = rx_cnt + CNT_W'(1);
                     crc_d = crc_byte(crc_q, {sym_dec[3:0], lo_nib_q});
                     odd_d = 1'b0;
                  end
               end else if (eop_now) begin
                  eop_d   = 1'b1;
                  ok_d    = (crc_q == CRC_RESIDUE) && (rx_cnt >= CNT_W'(6));
                  state_d = HUNT;
                  sr_d    = '0;
               end else begin
                  err_d   = 1'b1;
                  state_d = HUNT;
                  sr_d    = '0;
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         state_q   <= HUNT;
         sr_q      <= '0;
         bit_cnt_q <= 3'd0;
         odd_q     <= 1'b0;
         lo_nib_q  <= 4'h0;
         crc_q     <= 32'hFFFFFFFF;
         rx_sop    <= 1'b0;
         rx_ordrs  <= 3'd0;
         rx_dv     <= 1'b0;
         rx_dat    <= 8'h00;
         rx_cnt    <= '0;
         rx_eop    <= 1'b0;
         rx_crc_ok <= 1'b0;
         rx_err    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
         odd_q     <= odd_d;
         lo_nib_q  <= lo_nib_d;
         crc_q     <= crc_d;
         rx_sop    <= sop_d;
         rx_ordrs  <= ordrs_d;
         rx_dv     <= dv_d;
         rx_dat    <= dat_d;
         rx_cnt    <= cnt_d;
         rx_eop    <= eop_d;
         rx_crc_ok <= ok_d;
         rx_err    <= err_d;
      end
   end

endmodule

// File: tb/tb_usbpd_rx_sym_decoder.sv
// tb/tb_usbpd_rx_sym_decoder.sv - scoreboard bench for usbpd_rx_sym_decoder.
module tb_usbpd_rx_sym_decoder;
   localparam int CNT_W = 6;

   logic             clk = 1'b0;
   logic             rstz = 1'b0;
   logic             bit_vld = 1'b0;
   logic             bit_dat = 1'b0;
   logic             bmc_idle = 1'b0;
   logic             rx_sop, rx_dv, rx_eop, rx_crc_ok, rx_err;
   logic [2:0]       rx_ordrs;
   logic [7:0]       rx_dat;
   logic [CNT_W-1:0] rx_cnt;

   localparam logic [4:0] S1 = 5'b11000, S2 = 5'b10001, S3 = 5'b00110;
   localparam logic [4:0] R1 = 5'b00111, R2 = 5'b11001, EOP = 5'b01101;

   typedef struct {int kind; int v1; int v2;} ev_t;
   ev_t sb[$];
   int checks = 0;
   int errors = 0;
   logic [7:0] pl[$];

   usbpd_rx_sym_decoder #(.MAX_BYTE(34), .CNT_W(CNT_W)) dut (
      .clk(clk), .rstz(rstz), .bit_vld(bit_vld), .bit_dat(bit_dat), .bmc_idle(bmc_idle),
      .rx_sop(rx_sop), .rx_ordrs(rx_ordrs), .rx_dv(rx_dv), .rx_dat(rx_dat), .rx_cnt(rx_cnt),
      .rx_eop(rx_eop), .rx_crc_ok(rx_crc_ok), .rx_err(rx_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int k, input int a, input int b);
      ev_t e;
      e.kind = k; e.v1 = a; e.v2 = b;
      sb.push_back(e);
   endtask

   // kinds: 1 sop(ordrs), 2 dv(dat,cnt), 3 eop(crc_ok,cnt), 4 err
   task automatic take(input int k, input int a, input int b);
      ev_t e;
      if (sb.size() == 0) begin
         chk("unexpected_event_kind", k, 0);
      end else begin
         e = sb.pop_front();
         chk("event_kind", k, e.kind);
         if (k != 4) chk($sformatf("ev%0d_v1", k), a, e.v1);
         if (k == 2 || k == 3) chk($sformatf("ev%0d_cnt", k), b, e.v2);
      end
   endtask

   always @(negedge clk) begin
      if (rstz) begin
         if (rx_sop) take(1, int'(rx_ordrs), 0);
         if (rx_dv)  take(2, int'(rx_dat), int'(rx_cnt));
         if (rx_eop) take(3, int'(rx_crc_ok), int'(rx_cnt));
         if (rx_err) take(4, 0, 0);
      end
   end

   function automatic logic [4:0] enc(input logic [3:0] n);
      case (n)
         4'h0: return 5'b11110;  4'h1: return 5'b01001;
         4'h2: return 5'b10100;  4'h3: return 5'b10101;
         4'h4: return 5'b01010;  4'h5: return 5'b01011;
         4'h6: return 5'b01110;  4'h7: return 5'b01111;
         4'h8: return 5'b10010;  4'h9: return 5'b10011;
         4'hA: return 5'b10110;  4'hB: return 5'b10111;
         4'hC: return 5'b11010;  4'hD: return 5'b11011;
         4'hE: return 5'b11100;  default: return 5'b11101;
      endcase
   endfunction

   function automatic logic [31:0] crc32(input logic [7:0] d[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (d[i]) begin
         c = c ^ {24'h0, d[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return ~c;
   endfunction

   task automatic send_bit(input logic b, input logic idl);
      bit_vld = 1'b1; bit_dat = b; bmc_idle = idl;
      @(negedge clk);
      bit_vld = 1'b0; bmc_idle = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic send_sym(input logic [4:0] s, input logic idle_last);
      for (int i = 0; i < 5; i++) send_bit(s[i], idle_last && (i == 4));
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_sym(enc(b[3:0]), 1'b0);
      send_sym(enc(b[7:4]), 1'b0);
   endtask

   task automatic send_os(input int code, input logic [4:0] a, b, c, d);
      if (code != 0) push(1, code, 0);
      for (int i = 0; i < 64; i++) send_bit(i[0], 1'b0);
      send_sym(a, 1'b0); send_sym(b, 1'b0); send_sym(c, 1'b0); send_sym(d, 1'b0);
   endtask

   task automatic data_pkt(input logic [7:0] p[$], input logic flip, input logic idle_last);
      logic [7:0]  all[$];
      logic [31:0] c;
      all = p;
      c = crc32(p);
      if (flip) c[3] = ~c[3];
      for (int i = 0; i < 4; i++) all.push_back(c[8*i +: 8]);
      foreach (all[i]) push(2, int'(all[i]), i + 1);
      push(3, (!flip && all.size() >= 6) ? 1 : 0, all.size());
      foreach (all[i]) send_byte(all[i]);
      send_sym(EOP, idle_last);
   endtask

   task automatic drain(input string tag);
      repeat (12) @(negedge clk);
      chk(tag, sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_sop", rx_sop, 0);     chk("rst_ordrs", rx_ordrs, 0);
      chk("rst_dv", rx_dv, 0);       chk("rst_dat", rx_dat, 0);
      chk("rst_cnt", rx_cnt, 0);     chk("rst_eop", rx_eop, 0);
      chk("rst_crc_ok", rx_crc_ok, 0); chk("rst_err", rx_err, 0);
      rstz = 1'b1;
      repeat (2) @(negedge clk);

      // good SOP packet, header 0x0041
      send_os(1, S1, S1, S1, S2);
      pl = {8'h41, 8'h00};
      data_pkt(pl, 1'b0, 1'b0);
      drain("sop_good_drain");
      pl = {8'h41, 8'h00};
      chk("ordrs_hold", rx_ordrs, 1);
      chk("dat_hold", rx_dat, int'(crc32(pl) >> 24));
      chk("cnt_final", rx_cnt, 6);
      chk("crc_ok_hold", rx_crc_ok, 1);

      // valid CRC but only 5 bytes total: too short to be OK
      send_os(1, S1, S1, S1, S2);
      pl = {8'h55};
      data_pkt(pl, 1'b0, 1'b0);
      drain("short_drain");

      // SOP' with one corrupted symbol, GoodCRC 0x0141
      send_os(2, S1, S2, S3, S3);
      pl = {8'h41, 8'h01};
      data_pkt(pl, 1'b0, 1'b0);
      drain("sopp_1bad_drain");

      // two corrupted symbols: no match
      send_os(0, S1, S2, S2, S3);
      repeat (3) @(negedge clk);
      bmc_idle = 1'b1; @(negedge clk); bmc_idle = 1'b0;
      drain("sopp_2bad_drain");

      // Hard Reset, Cable Reset, then a normal packet
      send_os(6, R1, R1, R1, R2);
      drain("hr_drain");
      send_os(7, R1, S1, R1, S3);
      drain("cr_drain");
      send_os(1, S1, S1, S1, S2);
      pl = {8'h11, 8'h22};
      data_pkt(pl, 1'b0, 1'b0);
      drain("after_reset_drain");

      // flipped CRC bit
      send_os(1, S1, S1, S1, S2);
      pl = {8'h01, 8'h02, 8'h03};
      data_pkt(pl, 1'b1, 1'b0);
      drain("bad_crc_drain");

      // overflow: 35 data bytes
      send_os(1, S1, S1, S1, S2);
      for (int i = 0; i < 34; i++) push(2, (i * 7 + 3) & 8'hFF, i + 1);
      push(4, 0, 0);
      for (int i = 0; i < 35; i++) send_byte(8'((i * 7 + 3) & 8'hFF));
      drain("overflow_drain");

      // invalid symbol mid-byte
      send_os(3, S1, S3, S1, S3);
      push(2, 8'h12, 1); push(4, 0, 0);
      send_byte(8'h12); send_sym(enc(4'h3), 1'b0); send_sym(5'b00000, 1'b0);
      drain("invalid_sym_drain");

      // EOP at odd symbol position
      send_os(1, S1, S1, S1, S2);
      push(2, 8'h34, 1); push(4, 0, 0);
      send_byte(8'h34); send_sym(enc(4'h5), 1'b0); send_sym(EOP, 1'b0);
      drain("odd_eop_drain");

      // squelch mid-packet
      send_os(1, S1, S1, S1, S2);
      push(2, 8'hA5, 1); push(2, 8'h5A, 2); push(4, 0, 0);
      send_byte(8'hA5); send_byte(8'h5A);
      bmc_idle = 1'b1; @(negedge clk); bmc_idle = 1'b0;
      drain("idle_abort_drain");

      // squelch coincident with final EOP bit: EOP wins
      send_os(1, S1, S1, S1, S2);
      pl = {8'h41, 8'h00};
      data_pkt(pl, 1'b0, 1'b1);
      drain("idle_eop_drain");

      // async reset mid-packet: silent abort
      send_os(1, S1, S1, S1, S2);
      push(2, 8'h77, 1);
      send_byte(8'h77); send_sym(enc(4'h1), 1'b0);
      drain("pre_rst_drain");
      rstz = 1'b0;
      #1;
      chk("midrst_sop", rx_sop, 0);   chk("midrst_ordrs", rx_ordrs, 0);
      chk("midrst_dat", rx_dat, 0);   chk("midrst_cnt", rx_cnt, 0);
      chk("midrst_crc_ok", rx_crc_ok, 0); chk("midrst_err", rx_err, 0);
      repeat (3) @(negedge clk);
      rstz = 1'b1;
      @(negedge clk);
      send_os(2, S1, S1, S3, S3);
      pl = {8'hC3, 8'h3C, 8'h99};
      data_pkt(pl, 1'b0, 1'b0);
      drain("post_rst_drain");

      // debug ordered sets
`ifdef USBPD_RX_SOPDBG_EN
      send_os(4, S1, R2, R2, S3);
      push(4, 0, 0);
`else
      send_os(0, S1, R2, R2, S3);
`endif
      repeat (3) @(negedge clk);
      bmc_idle = 1'b1; @(negedge clk); bmc_idle = 1'b0;
      drain("dbg_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/usbpd_rx_sym_decoder.md
Name: usbpd_rx_sym_decoder

Overview:
- Synthesizable USB PD receive framer sitting directly downstream of the BMC bit recovery in the DUT PHY; it consumes recovered bits and produces framed packets.
- Its functions, in order: hunts for SOP* and Reset ordered sets, decodes 4b5b symbols into bytes, detects EOP, and checks CRC32.
- Its output stream feeds the protocol layer, which includes the auto-GoodCRC responder and the CSP command parser.
- The bench controller drives this block through rxd → BMC decoder.

Parameters:
MAX_BYTE, 34, max bytes per packet including CRC32 (2 header + 7×4 DO + 4 CRC); exceeding this is an error.
CNT_W, 6, width of the byte counter; must satisfy 2^CNT_W > MAX_BYTE.

Ports:
clk  input  1  system clock
rstz  input  1  asynchronous active-low reset
bit_vld  input  1  one-cycle strobe, one per UI, from the BMC decoder
bit_dat  input  1  recovered bit, qualified by bit_vld
bmc_idle  input  1  squelch/idle from the BMC decoder; level
rx_sop  output  1  one-cycle pulse: ordered set detected
rx_ordrs  output  3  ordered-set code, held until the next rx_sop: 1 SOP, 2 SOP', 3 SOP'', 4 SOP'_Dbg, 5 SOP''_Dbg, 6 Hard Reset, 7 Cable Reset, 0 none
rx_dv  output  1  one-cycle pulse: rx_dat valid
rx_dat  output  8  decoded byte, held until the next rx_dv
rx_cnt  output  CNT_W  bytes delivered in the current packet
rx_eop  output  1  one-cycle pulse: packet ended with EOP
rx_crc_ok  output  1  CRC32 residue check result; valid with rx_eop, held afterwards
rx_err  output  1  one-cycle pulse: packet aborted

Behaviour:
- Reset (rstz=0, async): all outputs 0, state HUNT, shift register cleared. Reset mid-packet aborts silently; no rx_err.
- Bit order and codes:
  - Bits are shifted LSB first into a 20-bit shift register, advanced only on bit_vld.
  - 5b codes are written as bits[4:0]: Sync-1=11000, Sync-2=10001, Sync-3=00110, RST-1=00111, RST-2=11001, EOP=01101.
  - Data codes follow the USB PD 4b5b table (0=11110 … F=11101).
- State HUNT:
  - On every bit_vld, compare the 4 symbols in the window against each ordered set.
  - A match requires at least 3 of 4 symbols to be correct.
  - Ordered sets: SOP=S1 S1 S1 S2; SOP'=S1 S1 S3 S3; SOP''=S1 S3 S1 S3; HR=R1 R1 R1 R2; CR=R1 S1 R1 S3.
  - Preamble (alternating 0/1) never matches.
- On a match:
  - rx_sop and rx_ordrs are issued the cycle after the qualifying bit_vld. rx_cnt clears to 0. Symbol alignment is fixed at this point.
  - HR/CR: go back to HUNT; no data and no EOP follow.
  - SOP*: go to DATA.
- State DATA:
  - Decoding:
    - Collect 5 bits per symbol. The first symbol is the low nibble, the second the high nibble.
    - After the second symbol: rx_dv pulses the cycle after its last bit_vld, and rx_cnt increments.
    - The byte is fed into the CRC32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected).
  - EOP at an even symbol position (byte boundary):
    - rx_eop pulses.
    - rx_crc_ok = (residue==0xC704DD7B) && rx_cnt≥6.
    - Go to HUNT.
  - Abort conditions: rx_err pulses and the state goes to HUNT, with no rx_eop. Any one of:
    - EOP at an odd position;
    - invalid or K symbol other than EOP;
    - rx_cnt would exceed MAX_BYTE;
    - bmc_idle asserted.
- Simultaneous bmc_idle and EOP completion in the same cycle: EOP wins.
- bit_vld is ignored while rstz=0. Back-to-back bit_vld on consecutive cycles is supported.
- rx_dv and rx_eop never pulse in the same cycle; rx_eop follows at least 5 bit_vld after the last rx_dv.

Optional Feature:
- Macro: USBPD_RX_SOPDBG_EN.
- Defined: SOP'_Debug (S1 R2 R2 S3 → code 4) and SOP''_Debug (S1 R2 S3 S2 → code 5) are matched with the same 3-of-4 rule and handled like SOP*.
- Undefined: these sets are never matched; codes 4/5 never appear and the block stays in HUNT.

Test Plan:
- Preamble(64 bits)+SOP+hdr 0x0041+CRC+EOP → rx_sop with ordrs=1; rx_dv ×6 with rx_dat 41,00,then CRC bytes; rx_eop; rx_crc_ok=1; rx_cnt=6.
- SOP' with 2nd symbol corrupted to Sync-2 (3/4 correct), then GoodCRC 0x0141 → rx_ordrs=2, rx_crc_ok=1. Same packet with 2 symbols corrupted → no rx_sop.
- Hard Reset R1 R1 R1 R2 → rx_sop with ordrs=6, no rx_dv/rx_eop, back in HUNT. A following SOP packet is accepted.
- SOP + 3 bytes + flipped CRC bit + EOP → rx_eop with rx_crc_ok=0. SOP + 35 data bytes → rx_err on 35th byte.
- SOP then invalid symbol 00000 mid-byte → rx_err; bmc_idle high mid-packet → rx_err; rstz low mid-packet → all outputs 0, no rx_err.
- With USBPD_RX_SOPDBG_EN: S1 R2 R2 S3 → ordrs=4. Without it: same stimulus → no rx_sop.
